// File: rtl/clause_loader.sv
// clause_loader: host-side streamer for the clause-arbiter load interface.
// Buffers a clause list and a unit-clause (UC) list written by the host. On
// host_go it replays the clause load burst, one finish pulse, then UC
// injection paced on carb_empty. It reports done/conflict back to the host.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   host_clear               clear both buffer counts, host_ovf and host_done
//   host_cla_push/host_cla   append a clause (accepted in IDLE/DONE only)
//   host_uc_push/host_uc     append a UC literal (accepted in IDLE/DONE only)
//   host_go                  start a run (single-cycle pulse)
//   host_busy/host_done      run status
//   host_conflict            last run ended in conflict (valid with host_done)
//   host_ovf                 sticky: a push was dropped on a full buffer
//   mem2carb_*               registered load interface towards the arbiter
//   carb_empty, conflict     arbiter status inputs
//   perf_cycles              saturating busy-cycle counter (optional)
//
// Optional feature: define CLAUSE_LOADER_PERF_EN to add perf_cycles.
module clause_loader #(
  parameter int unsigned CLA_DEPTH = 256,
  parameter int unsigned UC_DEPTH  = 32,
  parameter int unsigned UC_GAP    = 4,
  parameter int unsigned DRAIN_CYC = 8,
  parameter int unsigned LIT_W     = 16,
  parameter int unsigned CLA_W     = 3 * LIT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_clear,
  input  logic             host_cla_push,
  input  logic [CLA_W-1:0] host_cla,
  input  logic             host_uc_push,
  input  logic [LIT_W-1:0] host_uc,
  input  logic             host_go,
  output logic             host_busy,
  output logic             host_done,
  output logic             host_conflict,
  output logic             host_ovf,
  output logic             mem2carb_start,
  output logic             mem2carb_finish,
  output logic [CLA_W-1:0] mem2carb_clause,
  output logic             mem2carb_uc_valid,
  output logic [LIT_W-1:0] mem2carb_uc,
  input  logic             carb_empty,
  input  logic             conflict
`ifdef CLAUSE_LOADER_PERF_EN
  ,
  output logic [31:0]      perf_cycles
`endif
);

  localparam int unsigned CCW = $clog2(CLA_DEPTH + 1);
  localparam int unsigned UCW = $clog2(UC_DEPTH + 1);
  localparam int unsigned CIW = (CLA_DEPTH > 1) ? $clog2(CLA_DEPTH) : 1;
  localparam int unsigned UIW = (UC_DEPTH > 1) ? $clog2(UC_DEPTH) : 1;
  localparam int unsigned GW  = (UC_GAP > 1) ? $clog2(UC_GAP) : 1;
  localparam int unsigned DW  = $clog2(DRAIN_CYC + 1);

  typedef logic [LIT_W-1:0] lit_t;
  typedef logic [CLA_W-1:0] cla_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FINISH, S_UC_WAIT, S_UC_SEND, S_DRAIN, S_DONE
  } state_t;

  cla_t cla_buf [CLA_DEPTH];
  lit_t uc_buf  [UC_DEPTH];

  state_t         state_q, state_d;
  logic [CCW-1:0] cla_cnt_q, cla_cnt_d, rd_ptr_q, rd_ptr_d;
  logic [UCW-1:0] uc_cnt_q, uc_cnt_d, uc_ptr_q, uc_ptr_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [DW-1:0]  dcnt_q, dcnt_d;
  logic           ovf_q, ovf_d, done_q, done_d, hconf_q, hconf_d;
  logic           busy_q, start_q, finish_q, ucv_q;
  cla_t           clause_q;
  lit_t           uc_q;
  logic           host_idle, cla_wr, uc_wr, go_acc;

  assign host_idle = (state_q == S_IDLE) || (state_q == S_DONE);

  always_comb begin
    state_d   = state_q;
    cla_cnt_d = cla_cnt_q;
    uc_cnt_d  = uc_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    uc_ptr_d  = uc_ptr_q;
    gap_d     = gap_q;
    dcnt_d    = dcnt_q;
    ovf_d     = ovf_q;
    done_d    = done_q;
    hconf_d   = hconf_q;
    cla_wr    = 1'b0;
    uc_wr     = 1'b0;
    go_acc    = 1'b0;

    if (host_clear) begin
      cla_cnt_d = '0;
      uc_cnt_d  = '0;
      ovf_d     = 1'b0;
      done_d    = 1'b0;
    end else if (host_idle) begin
      if (host_cla_push) begin
        if (cla_cnt_q == CCW'(CLA_DEPTH)) ovf_d = 1'b1;
        else begin
          cla_wr    = 1'b1;
          cla_cnt_d = cla_cnt_q + CCW'(1);
        end
      end
      if (host_uc_push) begin
        if (uc_cnt_q == UCW'(UC_DEPTH)) ovf_d = 1'b1;
        else begin
          uc_wr    = 1'b1;
          uc_cnt_d = uc_cnt_q + UCW'(1);
        end
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (host_clear) begin
          state_d = S_IDLE;
        end else if (host_go) begin
          go_acc   = 1'b1;
          rd_ptr_d = '0;
          uc_ptr_d = '0;
          gap_d    = '0;
          dcnt_d   = '0;
          done_d   = 1'b0;
          hconf_d  = 1'b0;
          state_d  = (cla_cnt_q != '0) ? S_LOAD : S_FINISH;
        end
      end
      // rd_ptr tracks the clause currently on mem2carb_clause; the output
      // register is loaded from rd_ptr_d so data lines up with the strobe.
      S_LOAD: begin
        if ((rd_ptr_q + CCW'(1)) >= cla_cnt_q) state_d = S_FINISH;
        else rd_ptr_d = rd_ptr_q + CCW'(1);
      end
      S_FINISH: begin
        if (conflict) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          hconf_d = 1'b1;
        end else begin
          state_d = (uc_cnt_q != '0) ? S_UC_WAIT : S_DRAIN;
        end
      end
      // The gap counter is loaded on the edge that enters UC_SEND and keeps
      // counting through the send cycle, giving UC_GAP cycles start-to-start.
      S_UC_WAIT: begin
        if (conflict) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          hconf_d = 1'b1;
        end else if (gap_q != '0) begin
          gap_d = gap_q - GW'(1);
        end else if (carb_empty) begin
          state_d = S_UC_SEND;
          gap_d   = GW'(UC_GAP - 1);
        end
      end
      S_UC_SEND: begin
        uc_ptr_d = uc_ptr_q + UCW'(1);
        if (gap_q != '0) gap_d = gap_q - GW'(1);
        if (conflict) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          hconf_d = 1'b1;
        end else if ((uc_ptr_q + UCW'(1)) >= uc_cnt_q) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end else begin
          state_d = S_UC_WAIT;
        end
      end
      S_DRAIN: begin
        if (conflict) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          hconf_d = 1'b1;
        end else if (!carb_empty) begin
          dcnt_d = '0;
        end else if (dcnt_q == DW'(DRAIN_CYC - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          hconf_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cla_wr) cla_buf[cla_cnt_q[CIW-1:0]] <= host_cla;
    if (uc_wr)  uc_buf[uc_cnt_q[UIW-1:0]]   <= host_uc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cla_cnt_q <= '0;
      uc_cnt_q  <= '0;
      rd_ptr_q  <= '0;
      uc_ptr_q  <= '0;
      gap_q     <= '0;
      dcnt_q    <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      hconf_q   <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      finish_q  <= 1'b0;
      ucv_q     <= 1'b0;
      clause_q  <= '0;
      uc_q      <= '0;
    end else begin
      state_q   <= state_d;
      cla_cnt_q <= cla_cnt_d;
      uc_cnt_q  <= uc_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      uc_ptr_q  <= uc_ptr_d;
      gap_q     <= gap_d;
      dcnt_q    <= dcnt_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      hconf_q   <= hconf_d;
      busy_q    <= (state_d != S_IDLE) && (state_d != S_DONE);
      start_q   <= (state_d == S_LOAD);
      finish_q  <= (state_d == S_FINISH);
      ucv_q     <= (state_d == S_UC_SEND);
      clause_q  <= (state_d == S_LOAD) ? cla_buf[rd_ptr_d[CIW-1:0]] : '0;
      uc_q      <= (state_d == S_UC_SEND) ? uc_buf[uc_ptr_d[UIW-1:0]] : '0;
    end
  end

  assign host_busy         = busy_q;
  assign host_done         = done_q;
  assign host_conflict     = hconf_q;
  assign host_ovf          = ovf_q;
  assign mem2carb_start    = start_q;
  assign mem2carb_finish   = finish_q;
  assign mem2carb_clause   = clause_q;
  assign mem2carb_uc_valid = ucv_q;
  assign mem2carb_uc       = uc_q;

`ifdef CLAUSE_LOADER_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       perf_q <= '0;
    else if (go_acc)               perf_q <= '0;
    else if (busy_q && perf_q != '1) perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`endif

endmodule
